// File: rtl/bp_update_ctrl_pkg.sv
// Shared branch-predictor definitions: local-table encodings, update FSM
// states and the resolved-branch queue entry layout.
package bp_update_ctrl_pkg;

  // History-selected local table (upper bit = older outcome, T=1).
  typedef enum logic [1:0] {
    BP_UU = 2'd0,
    BP_UT = 2'd1,
    BP_TU = 2'd2,
    BP_TT = 2'd3
  } bp_table_e;

  // Update controller states.
  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bp_state_e;

  localparam int unsigned BP_IDX_W = 8;

  // Queue entry at the default index width; the controller packs its
  // FIFO word in the same {table, idx, taken} order for any IDX_W.
  typedef struct packed {
    bp_table_e             tbl;
    logic [BP_IDX_W-1:0]   idx;
    logic                  taken;
  } bp_entry_t;

  // A resolving conditional branch in a non-stalled execute stage.
  function automatic logic bp_is_capture(input logic [1:0] op, input logic stall);
    return op[0] & ~stall;
  endfunction

endpackage

// File: rtl/bp_upd_fifo.sv
// Small synchronous FIFO holding resolved branches awaiting a table write.
// DEPTH must be a power of two so the pointers wrap naturally.
module bp_upd_fifo #(
  parameter int unsigned W     = 11,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [W-1:0]             push_data_i,
  input  logic                     pop_i,
  output logic [W-1:0]             head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign full_o  = (count == CNT_FULL);
  assign empty_o = (count == '0);
  assign count_o = count;
  assign head_o  = mem[rd_ptr];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Entry storage; contents are only meaningful while counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

  // Pointer and occupancy bookkeeping; clr_i empties the queue.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// Branch-predictor update controller: sweeps all table entries on reset or
// flush, then trains the local tables from a queue of resolved branches.
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W      = BP_IDX_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             stall_e_i,
  input  logic [1:0]       branch_op_e_i,
  input  logic             pc_src_res_e_i,
  input  logic [IDX_W-1:0] idx_e_i,
  input  logic [1:0]       local_src_e_i,
  input  logic             flush_i,
  input  logic             upd_ready_i,
  output logic             upd_we_o,
  output logic             upd_init_o,
  output logic [1:0]       upd_table_o,
  output logic [IDX_W-1:0] upd_idx_o,
  output logic             upd_taken_o,
  output logic             init_done_o,
  output logic             dropped_o
);

  localparam int unsigned ENT_W = IDX_W + 3;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = '1;
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  bp_state_e        state;
  logic [IDX_W-1:0] init_cnt;
  logic             drop_q;

  logic             in_run;
  logic             cap_run;
  logic             deq;
  logic             enq;
  logic             drop_d;
  logic [ENT_W-1:0] cap_entry;
  logic [ENT_W-1:0] head;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;

  assign in_run      = (state == ST_RUN);
  assign init_done_o = in_run;
  assign dropped_o   = drop_q;

  // Captures outside RUN, or coincident with a flush, are discarded silently.
  assign cap_run   = in_run & ~flush_i & bp_is_capture(branch_op_e_i, stall_e_i);
  assign deq       = in_run & ~q_empty & upd_ready_i;
  assign enq       = cap_run & (~q_full | deq);
  assign drop_d    = cap_run & ~deq & (q_count == CNT_FULL);
  assign cap_entry = {local_src_e_i, idx_e_i, pc_src_res_e_i};

  bp_upd_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .clr_i       (flush_i),
    .push_i      (enq),
    .push_data_i (cap_entry),
    .pop_i       (deq),
    .head_o      (head),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .count_o     (q_count)
  );

  // INIT sweep counter, state transitions and the registered drop pulse.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state    <= ST_INIT;
      init_cnt <= '0;
      drop_q   <= 1'b0;
    end else begin
      drop_q <= drop_d;
      if (flush_i) begin
        state    <= ST_INIT;
        init_cnt <= '0;
      end else if (state == ST_INIT && upd_ready_i) begin
        init_cnt <= init_cnt + IDX_ONE;
        if (init_cnt == IDX_LAST) state <= ST_RUN;
      end
    end
  end

  // Table write port: init broadcast in INIT, queue head in RUN.
  always_comb begin
    upd_we_o    = 1'b1;
    upd_init_o  = 1'b1;
    upd_table_o = '0;
    upd_idx_o   = init_cnt;
    upd_taken_o = 1'b0;
    if (in_run) begin
      upd_we_o   = ~q_empty;
      upd_init_o = 1'b0;
      upd_idx_o  = '0;
      if (!q_empty) begin
        upd_table_o = head[ENT_W-1 -: 2];
        upd_idx_o   = head[IDX_W:1];
        upd_taken_o = head[0];
      end
    end
  end

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed scoreboard bench for bp_update_ctrl (IDX_W=8, FIFO_DEPTH=4).
module tb_bp_update_ctrl;

  typedef struct packed {
    logic [1:0] tbl;
    logic [7:0] idx;
    logic       tk;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b1;
  logic       stall_e_i = 1'b0;
  logic [1:0] branch_op_e_i = 2'b00;
  logic       pc_src_res_e_i = 1'b0;
  logic [7:0] idx_e_i = '0;
  logic [1:0] local_src_e_i = '0;
  logic       flush_i = 1'b0;
  logic       upd_ready_i = 1'b1;
  logic       upd_we_o;
  logic       upd_init_o;
  logic [1:0] upd_table_o;
  logic [7:0] upd_idx_o;
  logic       upd_taken_o;
  logic       init_done_o;
  logic       dropped_o;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   drops_seen = 0;
  exp_t sb_q[$];
  logic mdl_run = 1'b0;
  logic [7:0] mdl_cnt = '0;

  bp_update_ctrl #(
    .IDX_W      (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .stall_e_i      (stall_e_i),
    .branch_op_e_i  (branch_op_e_i),
    .pc_src_res_e_i (pc_src_res_e_i),
    .idx_e_i        (idx_e_i),
    .local_src_e_i  (local_src_e_i),
    .flush_i        (flush_i),
    .upd_ready_i    (upd_ready_i),
    .upd_we_o       (upd_we_o),
    .upd_init_o     (upd_init_o),
    .upd_table_o    (upd_table_o),
    .upd_idx_o      (upd_idx_o),
    .upd_taken_o    (upd_taken_o),
    .init_done_o    (init_done_o),
    .dropped_o      (dropped_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_br(input logic [1:0] op, input logic [1:0] src,
                        input logic [7:0] ix, input logic tk);
    branch_op_e_i  = op;
    local_src_e_i  = src;
    idx_e_i        = ix;
    pc_src_res_e_i = tk;
  endtask

  task automatic no_br();
    branch_op_e_i = 2'b00;
  endtask

  // Compare the current outputs with the model, advance the model for the
  // inputs now applied, clock once, then compare the drop pulse.
  task automatic step();
    logic cap, pop, exp_drop;
    int   sz;
    exp_t e;
    check("init_done", init_done_o, mdl_run);
    if (!mdl_run) begin
      check("init_we", upd_we_o, 1);
      check("init_flag", upd_init_o, 1);
      check("init_idx", upd_idx_o, mdl_cnt);
      check("init_table", upd_table_o, 0);
    end else begin
      check("run_we", upd_we_o, sb_q.size() != 0);
      check("run_init_flag", upd_init_o, 0);
      if (sb_q.size() != 0) begin
        check("head_table", upd_table_o, sb_q[0].tbl);
        check("head_idx", upd_idx_o, sb_q[0].idx);
        check("head_taken", upd_taken_o, sb_q[0].tk);
      end
    end
    cap      = branch_op_e_i[0] && !stall_e_i;
    sz       = sb_q.size();
    pop      = mdl_run && upd_ready_i && (sz != 0);
    exp_drop = 1'b0;
    if (flush_i) begin
      sb_q.delete();
      mdl_run = 1'b0;
      mdl_cnt = '0;
    end else if (!mdl_run) begin
      if (upd_ready_i) begin
        if (mdl_cnt == 8'hFF) mdl_run = 1'b1;
        mdl_cnt = mdl_cnt + 8'd1;
      end
    end else begin
      if (pop) void'(sb_q.pop_front());
      if (cap) begin
        if (sz < 4 || pop) begin
          e.tbl = local_src_e_i;
          e.idx = idx_e_i;
          e.tk  = pc_src_res_e_i;
          sb_q.push_back(e);
        end else begin
          exp_drop = 1'b1;
        end
      end
    end
    @(posedge clk_i);
    #1;
    check("dropped", dropped_o, exp_drop);
    if (dropped_o === 1'b1) drops_seen++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, upd_we_o, 1);
    check({tag, "_init"}, upd_init_o, 1);
    check({tag, "_idx"}, upd_idx_o, 0);
    check({tag, "_table"}, upd_table_o, 0);
    check({tag, "_taken"}, upd_taken_o, 0);
    check({tag, "_done"}, init_done_o, 0);
    check({tag, "_drop"}, dropped_o, 0);
  endtask

  initial begin
    // Power-on reset: outputs held at their reset values.
    #1 reset_n_i = 1'b0;
    #1 check_reset_outputs("por");
    @(posedge clk_i);
    #1;
    check_reset_outputs("por_held");
    reset_n_i = 1'b1;

    // Full sweep with ready held high: RUN after exactly 256 cycles.
    for (int i = 0; i < 256; i++) step();
    check("sweep256_done", init_done_o, 1);

    // Single TU/taken branch at 0x3A: written the next cycle for one cycle.
    set_br(2'b01, 2'b10, 8'h3A, 1'b1);
    step();
    no_br();
    check("single_we", upd_we_o, 1);
    check("single_table", upd_table_o, 2);
    check("single_idx", upd_idx_o, 8'h3A);
    check("single_taken", upd_taken_o, 1);
    step();
    check("single_we_gone", upd_we_o, 0);

    // Six back-to-back branches with ready low: four queued, two dropped.
    upd_ready_i = 1'b0;
    drops_seen  = 0;
    for (int k = 0; k < 6; k++) begin
      set_br((k % 2 == 0) ? 2'b01 : 2'b11, 2'(k), 8'(8'h10 + k), 1'(k % 2));
      step();
    end
    no_br();
    check("six_drop_pulses", drops_seen, 2);
    step();
    upd_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("six_drained", upd_we_o, 0);

    // Full queue with a capture coincident with a dequeue: accepted, no drop.
    upd_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_br(2'b01, 2'b11, 8'(8'hC0 + k), 1'b0);
      step();
    end
    drops_seen  = 0;
    upd_ready_i = 1'b1;
    set_br(2'b01, 2'b01, 8'h99, 1'b1);
    step();
    no_br();
    check("coincident_no_drop", drops_seen, 0);
    check("coincident_depth", sb_q.size(), 4);
    for (int k = 0; k < 4; k++) step();
    check("coincident_drained", upd_we_o, 0);

    // Stalled or unconditional branches are never queued.
    stall_e_i = 1'b1;
    set_br(2'b01, 2'b11, 8'h55, 1'b1);
    step();
    step();
    stall_e_i = 1'b0;
    set_br(2'b10, 2'b11, 8'h56, 1'b1);
    step();
    no_br();
    check("stall_not_queued", upd_we_o, 0);

    // Flush with three entries queued plus a same-cycle capture.
    upd_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_br(2'b01, 2'b00, 8'(8'hE0 + k), 1'b1);
      step();
    end
    flush_i = 1'b1;
    set_br(2'b01, 2'b10, 8'hEF, 1'b1);
    step();
    flush_i = 1'b0;
    no_br();
    check("flush_done", init_done_o, 0);
    check("flush_init", upd_init_o, 1);
    check("flush_idx", upd_idx_o, 0);
    check("flush_queue_model", sb_q.size(), 0);

    // Ready toggling during INIT (branches ignored): 512 cycles to RUN.
    for (int i = 0; i < 512; i++) begin
      upd_ready_i = 1'(i % 2);
      if (i % 7 == 3) set_br(2'b01, 2'b11, 8'(i), 1'b1);
      else no_br();
      step();
    end
    no_br();
    upd_ready_i = 1'b1;
    check("toggle512_done", init_done_o, 1);
    check("toggle512_empty", upd_we_o, 0);

    // Flush held high: stays in INIT at index 0.
    flush_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    flush_i = 1'b0;
    check("flush_held_idx", upd_idx_o, 0);
    for (int i = 0; i < 256; i++) step();
    check("resweep_done", init_done_o, 1);

    // Reset mid-RUN with entries queued discards everything.
    upd_ready_i = 1'b0;
    set_br(2'b01, 2'b01, 8'h77, 1'b1);
    step();
    set_br(2'b01, 2'b10, 8'h78, 1'b0);
    step();
    no_br();
    #2 reset_n_i = 1'b0;
    #1 check_reset_outputs("midrun");
    sb_q.delete();
    mdl_run = 1'b0;
    mdl_cnt = '0;
    @(posedge clk_i);
    #1;
    check_reset_outputs("midrun_held");
    reset_n_i   = 1'b1;
    upd_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) step();
    check("after_reset_done", init_done_o, 1);
    step();
    check("after_reset_empty", upd_we_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
